intcode_bit_serializer7: RTL and testbench
==========================================

Name: intcode_bit_serializer7

Overview:
- Inverse of the 7-bit packer used in the Intcode datapath: accepts one 8-bit byte, unpacks bits 0..6 and streams them one bit per handshake.
- Also exposes the captured byte split into individual weight bits (1, 2, 4, … 64).
- Sits between the Intcode byte bus and bit-serial consumers.
- Flags any byte whose bit 7 is set, because the packer always drives bit 7 to 0.

Parameters:
- NBITS, 7, number of payload bits streamed per byte (1..7); bits above NBITS-1 are ignored, except bit 7 for error checking.
- MSB_FIRST, 0, 0 = stream bit 0 first; 1 = stream bit NBITS-1 first.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  byte to unpack.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out valid.
- bit_ready  in  1  consumer accepts bit_out.
- bit_index  out  3  weight index (0..6) of the bit on bit_out.
- bit_last  out  1  bit_valid and this is the final bit of the byte.
- split_out  out  7  registered captured byte[6:0], i.e. bits for weights 1,2,4,8,16,32,64.
- err_bit7  out  1  sticky flag: an accepted byte had bit 7 = 1.
- clr_err  in  1  synchronous clear of err_bit7.

Behaviour:
- Reset (async assert, sync release on next edge): state=IDLE; in_ready=1; bit_valid=0; bit_out=0; bit_index=0; bit_last=0; split_out=0; err_bit7=0.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Bit transfer when bit_valid && bit_ready.
  - in_data is sampled only on transfer.
  - bit_out and bit_index hold stable while bit_valid && !bit_ready.
- FSM IDLE:
  - in_ready=1, bit_valid=0.
  - On input transfer: shreg <= in_data[NBITS-1:0]; split_out <= in_data[6:0]; cnt <= 0; go to SHIFT.
- FSM SHIFT:
  - in_ready=0 (see Optional Feature), bit_valid=1.
  - bit_index = cnt when MSB_FIRST=0, else NBITS-1-cnt.
  - bit_out = shreg[bit_index].
  - On bit transfer with cnt == NBITS-1: go to IDLE.
  - On any other bit transfer: cnt <= cnt+1.
- Latency: first bit valid the cycle after input transfer.
- Throughput: NBITS+1 cycles per byte with continuous ready (one IDLE bubble).
- cnt is 3 bits and never wraps past NBITS-1.
- split_out holds its value until the next input transfer; it is not cleared on return to IDLE.
- err_bit7:
  - Set on an input transfer with in_data[7]=1.
  - Cleared by clr_err.
  - If set and clear occur in the same cycle, set wins.
  - The erroneous byte is still accepted and streamed (bit 7 dropped).
- in_valid while in SHIFT: ignored and not consumed; the producer must hold the byte.
- Reset mid-stream: the remaining bits are discarded, with no partial bit_last.

Optional Feature:
- Macro: INTCODE_SER_BACK_TO_BACK_EN
- Defined:
  - in_ready is also asserted in SHIFT during the cycle where bit_last && bit_ready.
  - A simultaneous input transfer reloads shreg/split_out, sets cnt=0 and stays in SHIFT.
  - Throughput is NBITS cycles per byte, with no bubble.
  - err_bit7 is updated identically.
- Undefined:
  - in_ready = (state==IDLE) only.
  - One idle cycle between bytes.

Test Plan:
- Reset then idle -> in_ready=1, bit_valid=0, split_out=0, err_bit7=0; assert rst mid-SHIFT -> all outputs return to reset values immediately (async).
- Byte 0x55, bit_ready=1, defaults -> bit_out sequence 1,0,1,0,1,0,1 on indices 0..6; bit_last only on index 6; split_out=7'h55; next in_ready after 7 bit cycles.
- Byte 0x05 with MSB_FIRST=1, NBITS=7 -> sequence 0,0,0,0,1,0,1 with bit_index 6..0.
- Backpressure: 0x03 with bit_ready toggled 1,0,0,1,… -> bit_out/bit_index held during stalls; exactly 7 transfers; in_valid of 0x7F held during SHIFT is not consumed until IDLE.
- Byte 0x81 -> streams 1,0,0,0,0,0,0; err_bit7=1 and stays set; clr_err plus a 0x80 transfer in the same cycle -> err_bit7 stays 1; clr_err alone -> err_bit7=0.
- Bytes 0x7F then 0x00 with continuous valid/ready -> without macro, 15 cycles from first accept to second byte's last bit; with INTCODE_SER_BACK_TO_BACK_EN, 14 cycles and in_ready=1 on the first byte's bit_last cycle.

Source files
------------

// File: rtl/intcode_bit_serializer7.sv
// rtl/intcode_bit_serializer7.sv - unpacks one Intcode byte into a bit stream; optional INTCODE_SER_BACK_TO_BACK_EN
module intcode_bit_serializer7 #(
  parameter int NBITS     = 7,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic [2:0] bit_index,
  output logic       bit_last,
  output logic [6:0] split_out,
  output logic       err_bit7,
  input  logic       clr_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] LAST_CNT     = 3'(NBITS - 1);
  localparam logic [6:0] PAYLOAD_MASK = 7'((1 << NBITS) - 1);

  state_t     state;
  logic [6:0] shreg;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [2:0] first_idx;
  logic [2:0] next_idx;
  logic [6:0] load_bits;
  logic       in_xfer;
  logic       bit_xfer;

  // Map a stream position to the weight index of the bit sent at that position.
  function automatic logic [2:0] weight_of(input logic [2:0] pos);
    if (MSB_FIRST) begin
      return LAST_CNT - pos;
    end
    return pos;
  endfunction

  // Ready when idle; with back-to-back enabled also while the final bit is leaving.
`ifdef INTCODE_SER_BACK_TO_BACK_EN
  assign in_ready = (state == IDLE) || ((state == SHIFT) && bit_last && bit_ready);
`else
  assign in_ready = (state == IDLE);
`endif

  assign in_xfer   = in_valid && in_ready;
  assign bit_xfer  = bit_valid && bit_ready;
  assign cnt_nxt   = cnt + 3'd1;
  assign first_idx = weight_of(3'd0);
  assign next_idx  = weight_of(cnt_nxt);
  assign load_bits = in_data[6:0] & PAYLOAD_MASK;

  // Byte capture and bit sequencing; serial outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= 7'd0;
      cnt       <= 3'd0;
      split_out <= 7'd0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      bit_index <= 3'd0;
      bit_last  <= 1'b0;
    end else if (in_xfer) begin
      // A transfer only happens when idle or as the last bit leaves, so loading always wins.
      state     <= SHIFT;
      shreg     <= load_bits;
      split_out <= in_data[6:0];
      cnt       <= 3'd0;
      bit_valid <= 1'b1;
      bit_index <= first_idx;
      bit_out   <= load_bits[first_idx];
      bit_last  <= (LAST_CNT == 3'd0);
    end else if ((state == SHIFT) && bit_xfer) begin
      if (cnt == LAST_CNT) begin
        state     <= IDLE;
        cnt       <= 3'd0;
        bit_valid <= 1'b0;
        bit_out   <= 1'b0;
        bit_index <= 3'd0;
        bit_last  <= 1'b0;
      end else begin
        cnt       <= cnt_nxt;
        bit_index <= next_idx;
        bit_out   <= shreg[next_idx];
        bit_last  <= (cnt_nxt == LAST_CNT);
      end
    end
  end

  // Sticky bit-7 error; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bit7 <= 1'b0;
    end else if (in_xfer && in_data[7]) begin
      err_bit7 <= 1'b1;
    end else if (clr_err) begin
      err_bit7 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_intcode_bit_serializer7.sv
// tb/tb_intcode_bit_serializer7.sv - self-checking bench for intcode_bit_serializer7
module tb_intcode_bit_serializer7;

`ifdef INTCODE_SER_BACK_TO_BACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic [2:0] bit_index;
  logic       bit_last;
  logic [6:0] split_out;
  logic       err_bit7;
  logic       clr_err = 1'b0;

  logic [7:0] m_in_data = 8'd0;
  logic       m_in_valid = 1'b0;
  logic       m_in_ready;
  logic       m_bit_out;
  logic       m_bit_valid;
  logic       m_bit_ready = 1'b1;
  logic [2:0] m_bit_index;
  logic       m_bit_last;
  logic [6:0] m_split_out;
  logic       m_err_bit7;
  logic       m_clr_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  intcode_bit_serializer7 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_index(bit_index),
    .bit_last(bit_last), .split_out(split_out), .err_bit7(err_bit7), .clr_err(clr_err)
  );

  intcode_bit_serializer7 #(.NBITS(7), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .bit_out(m_bit_out), .bit_valid(m_bit_valid), .bit_ready(m_bit_ready), .bit_index(m_bit_index),
    .bit_last(m_bit_last), .split_out(m_split_out), .err_bit7(m_err_bit7), .clr_err(m_clr_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending {last, index, bit} entries for the whole byte.
  logic [4:0] mq[$];
  logic [6:0] m_split = 7'd0;
  logic       m_err   = 1'b0;

  function automatic logic exp_ready();
    return (mq.size() == 0) || (BTB && (mq.size() == 1) && bit_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_split = 7'd0;
      m_err   = 1'b0;
    end else begin
      logic inx;
      inx = in_valid && exp_ready();
      if ((mq.size() > 0) && bit_ready) void'(mq.pop_front());
      if (inx) begin
        for (int k = 0; k < 7; k++) begin
          logic [2:0] kk;
          kk = 3'(k);
          mq.push_back({(k == 6), kk, in_data[k]});
        end
        m_split = in_data[6:0];
      end
      if (inx && in_data[7]) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
    end
  end

  always @(posedge clk) cyc++;

  // Per-cycle comparison of the default-parameter DUT against the model.
  always @(negedge clk) begin
    chk("in_ready", in_ready, exp_ready());
    chk("bit_valid", bit_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("bit_out", bit_out, mq[0][0]);
      chk("bit_index", bit_index, mq[0][3:1]);
      chk("bit_last", bit_last, mq[0][4]);
    end else begin
      chk("bit_last_idle", bit_last, 1'b0);
    end
    chk("split_out", split_out, m_split);
    chk("err_bit7", err_bit7, m_err);
  end

  // Transfer logs used for literal expectations.
  logic [31:0] obs_bits;
  int          obs_n;
  int          last_cnt;
  logic [2:0]  last_idx;
  logic [6:0]  mb_bits;
  logic [20:0] mb_idx;
  int          mb_n;
  int          mb_last;

  always @(negedge clk) begin
    if (bit_valid && bit_ready && obs_n < 32) begin
      obs_bits[obs_n] = bit_out;
      if (bit_last) begin
        last_cnt++;
        last_idx = bit_index;
      end
      obs_n++;
    end
    if (m_bit_valid && m_bit_ready && mb_n < 7) begin
      mb_bits[mb_n] = m_bit_out;
      mb_idx[3*mb_n +: 3] = m_bit_index;
      if (m_bit_last) mb_last++;
      mb_n++;
    end
  end

  task automatic clear_log();
    obs_bits = 32'd0; obs_n = 0; last_cnt = 0; last_idx = 3'd0;
  endtask

  task automatic send(input logic [7:0] d, input logic clr);
    bit ok;
    ok = 1'b0;
    in_data = d; in_valid = 1'b1; clr_err = clr;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no in_ready expected in_ready within 40 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n_acc, n_last, t0, t1;
    logic rdy_at_last, acc;
    logic [3:0] pat;
    clear_log();
    mb_bits = 7'd0; mb_idx = 21'd0; mb_n = 0; mb_last = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_split", split_out, 7'h00);
    chk("rst_err", err_bit7, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // MSB-first instance: 0x05.
    m_in_data = 8'h05; m_in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 m_in_valid = 1'b0;
    idle(10);
    chk("msb_count", mb_n, 7);
    chk("msb_bits", mb_bits, 7'b1010000);
    chk("msb_idx", mb_idx, 21'o0123456);
    chk("msb_last", mb_last, 1);

    // 0x55, continuous ready.
    clear_log();
    send(8'h55, 1'b0);
    idle(10);
    chk("x55_count", obs_n, 7);
    chk("x55_bits", obs_bits[6:0], 7'h55);
    chk("x55_last_cnt", last_cnt, 1);
    chk("x55_last_idx", last_idx, 3'd6);
    chk("x55_split", split_out, 7'h55);

    // Backpressure on 0x03 with 0x7F held pending during SHIFT.
    clear_log();
    pat = 4'b1001;
    in_data = 8'h03; in_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc && in_data == 8'h03) in_data = 8'h7F;
      else if (acc) in_valid = 1'b0;
      bit_ready = pat[i % 4];
    end
    bit_ready = 1'b1;
    idle(10);
    chk("bp_count", obs_n, 14);
    chk("bp_first", obs_bits[6:0], 7'h03);
    chk("bp_second", obs_bits[13:7], 7'h7F);
    chk("bp_valid_drop", in_valid, 1'b0);

    // Bit-7 error handling.
    clear_log();
    send(8'h81, 1'b0);
    idle(10);
    chk("x81_bits", obs_bits[6:0], 7'h01);
    chk("x81_err", err_bit7, 1'b1);
    send(8'h80, 1'b1);
    chk("set_wins", err_bit7, 1'b1);
    idle(10);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("clr_err", err_bit7, 1'b0);

    // Throughput: 0x7F then 0x00 with continuous valid/ready.
    n_acc = 0; n_last = 0; t0 = 0; t1 = -100; rdy_at_last = 1'bx;
    in_data = 8'h7F; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) t0 = cyc;
      end
      if (bit_valid && bit_ready && bit_last) begin
        n_last++;
        if (n_last == 1) rdy_at_last = in_ready;
        if (n_last == 2) t1 = cyc;
      end
      @(posedge clk); #1;
      if (acc && n_acc == 1) in_data = 8'h00;
      else if (acc) in_valid = 1'b0;
    end
    chk("b2b_cycles", t1 - t0, BTB ? 32'd14 : 32'd15);
    chk("ready_on_last", rdy_at_last, BTB);

    // Asynchronous reset in the middle of a byte.
    send(8'h55, 1'b0);
    idle(3);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_bit_valid", bit_valid, 1'b0);
    chk("arst_bit_last", bit_last, 1'b0);
    chk("arst_bit_out", bit_out, 1'b0);
    chk("arst_bit_index", bit_index, 3'd0);
    chk("arst_split", split_out, 7'h00);
    chk("arst_err", err_bit7, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
